// File: rtl/gpu_regfile_pkg.sv
// Shared types and default sizing for the GPU shader register file.
// Collision behaviour is selected by GPU_REGFILE_BYPASS_EN (see gpu_regfile_rd_port).
package gpu_regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 16;
    localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/gpu_regfile_rd_port.sv
// One registered read port: range check, optional write-first bypass, data/valid registers.
// GPU_REGFILE_BYPASS_EN defined selects write-first; undefined selects read-first.
module gpu_regfile_rd_port
    import gpu_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(RF_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           busy_i,
    input  logic                           rd_en_i,
    input  logic [ADDR_W-1:0]              rd_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]   mem_i,
    input  logic                           wr_commit_i,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [DATA_W-1:0]              wr_data_i,
    output logic [DATA_W-1:0]              rd_data_o,
    output logic                           rd_valid_o
);

`ifdef GPU_REGFILE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              in_range_s;
    logic              bypass_s;

    assign in_range_s = ({1'b0, rd_addr_i} < (ADDR_W+1)'(DEPTH));
    assign bypass_s   = BYPASS_EN && wr_commit_i && (wr_addr_i == rd_addr_i);

    // Next-state for the read data/valid registers; out-of-range reads return zero.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en_i && !busy_i) begin
            rd_valid_d = 1'b1;
            if (!in_range_s) begin
                rd_data_d = {DATA_W{1'b0}};
            end else if (bypass_s) begin
                rd_data_d = wr_data_i;
            end else begin
                rd_data_d = mem_i[rd_addr_i];
            end
        end else begin
            rd_valid_d = 1'b0;
            rd_data_d  = rd_data_q;
        end
    end

    // Read output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/gpu_regfile.sv
// Multi-read-port register file with hardware clear sequencer (after reset or init_req).
// Same-address write/read collision result is set by GPU_REGFILE_BYPASS_EN.
module gpu_regfile
    import gpu_regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     init_req,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    rf_state_t                  state_q, state_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;
    logic                       clr_we_s;
    logic                       wr_commit_s;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    assign busy        = (state_q == CLEAR);
    assign wr_commit_s = wr_en && (state_q == IDLE) &&
                         ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

    // Clear sequencer next-state: walk every entry once, then serve accesses.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_s = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_s = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (init_req) begin
                    state_d = CLEAR;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage: contents are re-zeroed by the sequencer, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[ptr_q] <= {DATA_W{1'b0}};
        end else if (wr_commit_s) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        gpu_regfile_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .clk         (clk),
            .rst_n       (rst_n),
            .busy_i      (busy),
            .rd_en_i     (rd_en[p]),
            .rd_addr_i   (rd_addr[p*ADDR_W +: ADDR_W]),
            .mem_i       (mem_q),
            .wr_commit_i (wr_commit_s),
            .wr_addr_i   (wr_addr),
            .wr_data_i   (wr_data),
            .rd_data_o   (rd_data[p*DATA_W +: DATA_W]),
            .rd_valid_o  (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_gpu_regfile.sv
// Directed self-checking bench: a 16-entry instance and a 12-entry instance of gpu_regfile.
module tb_gpu_regfile;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        wr_en, init_req, busy;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en, rd_valid;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;

    logic        wr_en12, init_req12, busy12;
    logic [3:0]  wr_addr12;
    logic [31:0] wr_data12;
    logic [1:0]  rd_en12, rd_valid12;
    logic [7:0]  rd_addr12;
    logic [63:0] rd_data12;

    int checks = 0;
    int errors = 0;
    int cnt;
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    gpu_regfile #(.DATA_W(32), .DEPTH(16), .NUM_RD(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .init_req(init_req), .busy(busy)
    );

    gpu_regfile #(.DATA_W(32), .DEPTH(12), .NUM_RD(2)) dut12 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
        .rd_en(rd_en12), .rd_addr(rd_addr12), .rd_data(rd_data12), .rd_valid(rd_valid12),
        .init_req(init_req12), .busy(busy12)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd_both(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                           input logic [31:0] e0, input logic [31:0] e1);
        rd_en = 2'b11; rd_addr = {a1, a0};
        step();
        rd_en = 2'b00;
        check({tag, "_valid"}, 64'(rd_valid), 64'(2'b11));
        check({tag, "_p0"}, 64'(rd_data[31:0]), 64'(e0));
        check({tag, "_p1"}, 64'(rd_data[63:32]), 64'(e1));
    endtask

    task automatic count_busy(input string tag, input bit chk_valid);
        cnt = 0;
        while (busy && cnt < 100) begin
            step();
            cnt++;
            if (chk_valid) check({tag, "_rdvalid_busy"}, 64'(rd_valid), 64'(2'b00));
        end
        check({tag, "_busy_cycles"}, 64'(cnt), 64'd16);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; rd_en = 2'b00; rd_addr = 8'd0; init_req = 1'b0;
        wr_en12 = 1'b0; wr_addr12 = 4'd0; wr_data12 = 32'd0; rd_en12 = 2'b00; rd_addr12 = 8'd0;
        init_req12 = 1'b0;
        step();
        step();
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_data", rd_data, 64'd0);
        rst_n = 1'b1;

        // Clear after reset, then every entry reads zero on both ports.
        count_busy("reset_clear", 1'b1);
        for (int a = 0; a < 16; a++) rd_both("clear_entry", 4'(a), 4'(15 - a), 32'd0, 32'd0);

        // Basic write then dual-port read.
        wr(4'd5, 32'hDEADBEEF);
        rd_both("wr5_rd5", 4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // Same-cycle write/read collision on addr 3.
        wr(4'd3, 32'hAAAA0000);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        step();
        wr_en = 1'b0; rd_en = 2'b00;
`ifdef GPU_REGFILE_BYPASS_EN
        exp_v = 32'h12345678;
`else
        exp_v = 32'hAAAA0000;
`endif
        check("collision_valid", 64'(rd_valid), 64'(2'b01));
        check("collision_data", 64'(rd_data[31:0]), 64'(exp_v));
        rd_both("after_collision", 4'd3, 4'd5, 32'h12345678, 32'hDEADBEEF);
        rd_en = 2'b00;
        step();
        check("rd_en_low_valid", 64'(rd_valid), 64'd0);
        check("rd_en_low_hold", 64'(rd_data[31:0]), 64'(32'h12345678));

        // 12-entry instance: out-of-range write dropped, out-of-range read returns 0.
        check("d12_idle", 64'(busy12), 64'd0);
        wr_en12 = 1'b1; wr_addr12 = 4'd1; wr_data12 = 32'h11;
        step();
        wr_addr12 = 4'd13; wr_data12 = 32'h55;
        rd_en12 = 2'b01; rd_addr12 = {4'd0, 4'd13};
        step();
        wr_en12 = 1'b0;
        check("d12_oor_valid", 64'(rd_valid12), 64'(2'b01));
        check("d12_oor_data", 64'(rd_data12[31:0]), 64'd0);
        for (int a = 0; a < 12; a++) begin
            rd_en12 = 2'b01; rd_addr12 = {4'd0, 4'(a)};
            step();
            check("d12_entry_valid", 64'(rd_valid12), 64'(2'b01));
            check("d12_entry_data", 64'(rd_data12[31:0]), (a == 1) ? 64'h11 : 64'd0);
        end
        rd_addr12 = {4'd0, 4'd13};
        step();
        rd_en12 = 2'b00;
        check("d12_oor_again", 64'(rd_data12[31:0]), 64'd0);

        // Fill, then init_req: read on the request edge completes; clear ignores reads.
        for (int a = 0; a < 16; a++) wr(4'(a), 32'hC000_0000 | 32'(a));
        rd_both("fill_check", 4'd7, 4'd15, 32'hC000_0007, 32'hC000_000F);
        init_req = 1'b1; rd_en = 2'b11; rd_addr = {4'd9, 4'd5};
        step();
        init_req = 1'b0;
        check("init_busy", 64'(busy), 64'd1);
        check("init_edge_valid", 64'(rd_valid), 64'(2'b11));
        check("init_edge_p0", 64'(rd_data[31:0]), 64'(32'hC000_0005));
        check("init_edge_p1", 64'(rd_data[63:32]), 64'(32'hC000_0009));
        step();
        step();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("init_hold_data", 64'(rd_data[31:0]), 64'(32'hC000_0005));
        cnt = 3;
        while (busy && cnt < 100) begin
            step();
            cnt++;
            check("init_rdvalid_busy", 64'(rd_valid), 64'd0);
        end
        rd_en = 2'b00;
        check("init_busy_cycles", 64'(cnt), 64'd16);
        for (int a = 0; a < 16; a++) rd_both("init_cleared", 4'(a), 4'(a), 32'd0, 32'd0);

        // Reset in the middle of a clear restarts it from scratch.
        wr(4'd2, 32'h0000CAFE);
        init_req = 1'b1; rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
        step();
        init_req = 1'b0; rd_en = 2'b00;
        for (int i = 0; i < 7; i++) step();
        check("midclr_hold", 64'(rd_data[31:0]), 64'(32'h0000CAFE));
        check("midclr_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_rd_data", rd_data, 64'd0);
        check("midrst_rd_valid", 64'(rd_valid), 64'd0);
        step();
        rst_n = 1'b1;
        count_busy("midrst_clear", 1'b1);
        rd_both("midrst_entry2", 4'd2, 4'd5, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
